// File: rtl/stream_share2.sv
// stream_share2: round-robin sharing of one stream kernel between requesters A and B, with results returned in order using a tag FIFO
module stream_share2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             a_in_valid,
  output logic             a_in_ready,
  input  logic [WIDTH-1:0] a_in_data,
  output logic             a_out_valid,
  input  logic             a_out_ready,
  output logic [WIDTH-1:0] a_out_data,
  input  logic             b_in_valid,
  output logic             b_in_ready,
  input  logic [WIDTH-1:0] b_in_data,
  output logic             b_out_valid,
  input  logic             b_out_ready,
  output logic [WIDTH-1:0] b_out_data,
  output logic             k_in_valid,
  input  logic             k_in_ready,
  output logic [WIDTH-1:0] k_in_data,
  input  logic             k_out_valid,
  output logic             k_out_ready,
  input  logic [WIDTH-1:0] k_out_data,
  output logic             busy,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic prio_q, prio_d, err_q, err_d;
  logic full, empty, gnt_a, gnt_b, head, push, pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    gnt_a = a_in_valid & (!b_in_valid | !prio_q);
    gnt_b = b_in_valid & (!a_in_valid | prio_q);
    k_in_valid = (gnt_a | gnt_b) & !full;
    k_in_data = gnt_b ? b_in_data : a_in_data;
    a_in_ready = gnt_a & k_in_ready & !full;
    b_in_ready = gnt_b & k_in_ready & !full;
    push = k_in_valid & k_in_ready;
    head = tag_q[rp_q];
    a_out_valid = k_out_valid & !empty & !head;
    b_out_valid = k_out_valid & !empty & head;
    a_out_data = k_out_data;
    b_out_data = k_out_data;
    k_out_ready = !empty & (head ? b_out_ready : a_out_ready);
    pop = k_out_valid & k_out_ready;
    tag_d = tag_q;
    if (push) tag_d[wp_q] = gnt_b;
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    prio_d = push ? !gnt_b : prio_q;
    err_d = err_q | (k_out_valid & empty);
    busy = !empty;
    err = err_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tag_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      prio_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      prio_q <= prio_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_stream_share2.sv
// tb_stream_share2: vector table and hand sequences with a 1-cycle add-one kernel model and per-requester scoreboards
module tb_stream_share2;
  logic clk = 0, nrst = 0;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [7:0] a_in_data = 0, a_out_data, b_in_data = 0, b_out_data;
  logic k_in_valid, k_in_ready = 0, k_out_valid = 0, k_out_ready, busy, err;
  logic [7:0] k_in_data, k_out_data = 0;
  logic kout_en = 0;
  logic [7:0] kq[$], exp_a[$], exp_b[$], kin_log[$];
  int nvec = 0, nerr = 0, na = 0, sa = 0, sb = 0;
  typedef struct {
    logic av; logic [7:0] ad; logic bv; logic [7:0] bd; logic kr;
    logic ekv; logic [7:0] ekd; logic ear; logic ebr; logic ebusy;
  } vec_t;
  vec_t tbl[8];
  stream_share2 dut (
    .clk(clk), .nrst(nrst),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready), .a_in_data(a_in_data),
    .a_out_valid(a_out_valid), .a_out_ready(a_out_ready), .a_out_data(a_out_data),
    .b_in_valid(b_in_valid), .b_in_ready(b_in_ready), .b_in_data(b_in_data),
    .b_out_valid(b_out_valid), .b_out_ready(b_out_ready), .b_out_data(b_out_data),
    .k_in_valid(k_in_valid), .k_in_ready(k_in_ready), .k_in_data(k_in_data),
    .k_out_valid(k_out_valid), .k_out_ready(k_out_ready), .k_out_data(k_out_data),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task kdrive();
    k_out_valid = kout_en && kq.size() != 0;
    k_out_data = kq.size() != 0 ? kq[0] : 8'h0;
  endtask
  task tick();
    logic at, bt, kt, ao, bo, ko;
    logic [7:0] kd;
    kdrive();
    #1;
    at = a_in_valid & a_in_ready;
    bt = b_in_valid & b_in_ready;
    kt = k_in_valid & k_in_ready;
    ao = a_out_valid & a_out_ready;
    bo = b_out_valid & b_out_ready;
    ko = k_out_valid & k_out_ready;
    kd = k_in_data;
    if (at) begin exp_a.push_back(a_in_data + 8'd1); sa++; end
    if (bt) begin exp_b.push_back(b_in_data + 8'd1); sb++; end
    if (kt) kin_log.push_back(kd);
    if (ao) begin
      na++;
      if (exp_a.size() == 0) begin nvec++; nerr++; $display("FAIL a_out_unexpected: got %0h", a_out_data); end
      else chk("a_out_data", a_out_data, exp_a.pop_front());
    end
    if (bo) begin
      if (exp_b.size() == 0) begin nvec++; nerr++; $display("FAIL b_out_unexpected: got %0h", b_out_data); end
      else chk("b_out_data", b_out_data, exp_b.pop_front());
    end
    @(posedge clk);
    #1;
    if (ko) void'(kq.pop_front());
    if (kt) kq.push_back(kd + 8'd1);
    kdrive();
    @(negedge clk);
  endtask
  task do_reset();
    nrst = 0;
    a_in_valid = 0; b_in_valid = 0; k_in_ready = 0;
    a_out_ready = 1; b_out_ready = 1; kout_en = 0;
    kq.delete(); exp_a.delete(); exp_b.delete(); kin_log.delete();
    kdrive();
    @(negedge clk); @(negedge clk);
    nrst = 1;
  endtask
  task drain();
    a_in_valid = 0; b_in_valid = 0;
    a_out_ready = 1; b_out_ready = 1; kout_en = 1;
    for (int i = 0; i < 20; i++) begin
      if (kq.size() == 0 && exp_a.size() == 0 && exp_b.size() == 0) break;
      tick();
    end
    chk("drain_a_left", exp_a.size(), 0);
    chk("drain_b_left", exp_b.size(), 0);
    #1;
    chk("drain_busy", busy, 0);
  endtask
  initial begin
    tbl[0] = '{1'b0, 8'h11, 1'b0, 8'h21, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h30, 1'b0, 8'h40, 1'b1, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h31, 1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'h31, 1'b1, 8'h42, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'h31, 1'b1, 8'h42, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h31, 1'b1, 8'h42, 1'b1, 1'b1, 8'h42, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 8'h31, 1'b1, 8'h43, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h31, 1'b1, 8'h43, 1'b1, 1'b0, 8'h43, 1'b0, 1'b0, 1'b1};
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_k_in_valid", k_in_valid, 0);
    chk("rst_k_out_ready", k_out_ready, 0);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      a_in_valid = tbl[i].av; a_in_data = tbl[i].ad;
      b_in_valid = tbl[i].bv; b_in_data = tbl[i].bd;
      k_in_ready = tbl[i].kr;
      #1;
      chk($sformatf("v%0d_k_in_valid", i), k_in_valid, tbl[i].ekv);
      chk($sformatf("v%0d_k_in_data", i), k_in_data, tbl[i].ekd);
      chk($sformatf("v%0d_a_in_ready", i), a_in_ready, tbl[i].ear);
      chk($sformatf("v%0d_b_in_ready", i), b_in_ready, tbl[i].ebr);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].ebusy);
      tick();
    end
    drain();
    do_reset();
    k_in_ready = 1; kout_en = 1; na = 0;
    for (int i = 0; i < 16; i++) begin
      a_in_valid = 1; a_in_data = 8'(i);
      kdrive();
      #1;
      chk("t1_a_in_ready", a_in_ready, 1);
      chk("t1_b_out_valid", b_out_valid, 0);
      if (i > 0) chk("t1_a_out_valid", a_out_valid, 1);
      tick();
    end
    drain();
    chk("t1_returns", na, 16);
    chk("t1_err", err, 0);
    do_reset();
    k_in_ready = 1; kout_en = 1; sa = 0; sb = 0;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1; a_in_data = 8'(10 + sa);
      b_in_valid = 1; b_in_data = 8'(20 + sb);
      tick();
    end
    drain();
    chk("t2_issues", kin_log.size(), 8);
    for (int i = 0; i < 8 && i < kin_log.size(); i++)
      chk($sformatf("t2_kin%0d", i), kin_log[i], (i % 2 == 0) ? 10 + i / 2 : 20 + i / 2);
    do_reset();
    k_in_ready = 1; sa = 0; sb = 0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1; a_in_data = 8'(8'h50 + sa);
      b_in_valid = 1; b_in_data = 8'(8'h70 + sb);
      tick();
    end
    chk("t3_issues_full", kin_log.size(), 4);
    chk("t3_full_ready", a_in_ready | b_in_ready, 0);
    chk("t3_full_busy", busy, 1);
    kout_en = 1;
    kdrive();
    #1;
    chk("t3_pop_k_out_ready", k_out_ready, 1);
    chk("t3_pop_cycle_ready", a_in_ready | b_in_ready, 0);
    tick();
    kout_en = 0;
    kdrive();
    #1;
    chk("t3_after_pop_ready", a_in_ready | b_in_ready, 1);
    tick();
    #1;
    chk("t3_refull_ready", a_in_ready | b_in_ready, 0);
    chk("t3_issues_total", kin_log.size(), 5);
    drain();
    do_reset();
    k_in_ready = 1;
    a_in_valid = 1; a_in_data = 8'h60;
    tick();
    a_in_valid = 0; b_in_valid = 1; b_in_data = 8'h70;
    tick();
    b_in_valid = 0; a_out_ready = 0; kout_en = 1;
    for (int i = 0; i < 3; i++) begin
      kdrive();
      #1;
      chk("t4_a_out_valid", a_out_valid, 1);
      chk("t4_b_out_valid_blocked", b_out_valid, 0);
      chk("t4_k_out_ready", k_out_ready, 0);
      tick();
    end
    a_out_ready = 1;
    #1;
    chk("t4_a_first", a_out_data, 8'h61);
    tick();
    #1;
    chk("t4_b_next_valid", b_out_valid, 1);
    chk("t4_b_next_data", b_out_data, 8'h71);
    drain();
    do_reset();
    k_in_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1; a_in_data = 8'(i);
      tick();
    end
    a_in_valid = 0;
    #1;
    chk("t5_busy_before", busy, 1);
    #2 nrst = 0;
    #1;
    chk("t5_busy_async", busy, 0);
    exp_a.delete(); exp_b.delete();
    @(negedge clk);
    nrst = 1;
    a_in_valid = 1; a_in_data = 8'hA0;
    b_in_valid = 1; b_in_data = 8'hB0;
    k_in_ready = 0;
    #1;
    chk("t5_busy_after", busy, 0);
    chk("t5_err_after", err, 0);
    chk("t5_prio_a", k_in_data, 8'hA0);
    a_in_valid = 0; b_in_valid = 0;
    kout_en = 1;
    kdrive();
    #1;
    chk("t5_stale_k_out_valid", k_out_valid, 1);
    chk("t5_stale_a_out_valid", a_out_valid, 0);
    chk("t5_stale_b_out_valid", b_out_valid, 0);
    chk("t5_stale_k_out_ready", k_out_ready, 0);
    tick();
    #1;
    chk("t5_err_set", err, 1);
    kq.delete(); kout_en = 0;
    tick();
    #1;
    chk("t5_err_sticky", err, 1);
    do_reset();
    k_in_ready = 1; kout_en = 1;
    a_in_valid = 1; a_in_data = 8'hBF;
    tick();
    a_in_data = 8'hC0; b_in_valid = 1; b_in_data = 8'hD0; k_in_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_stall_k_in_valid", k_in_valid, 1);
      chk("t6_stall_k_in_data", k_in_data, 8'hD0);
      chk("t6_stall_b_in_ready", b_in_ready, 0);
      chk("t6_stall_a_in_ready", a_in_ready, 0);
      tick();
    end
    k_in_ready = 1;
    #1;
    chk("t6_b_in_ready", b_in_ready, 1);
    chk("t6_b_data", k_in_data, 8'hD0);
    tick();
    #1;
    chk("t6_prio_toggled", k_in_data, 8'hC0);
    chk("t6_a_in_ready", a_in_ready, 1);
    tick();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
